// File: rtl/acl_paddle_ctrl.sv
// ============================================================================
// Module   : acl_paddle_ctrl
// Function : Tilt-to-paddle controller. Moving-average filter, dead zone,
//            saturated velocity and clamped per-frame position integration.
// Options  : define ACL_CAL_EN to subtract the first full average as a
//            zero-tilt offset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acl_paddle_ctrl #(
    parameter int AVG_LOG2  = 2,
    parameter int DEADZONE  = 16,
    parameter int VEL_SHIFT = 4,
    parameter int MAX_STEP  = 8,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [9:0] sample_in,
    input  logic              sample_valid,
    input  logic              frame_tick,
    input  logic              frz,
    output logic signed [9:0] tilt_avg,
    output logic        [9:0] paddle_y,
    output logic              paddle_upd,
    output logic              cal_done
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 10 + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic        [9:0]  Y_HOME   = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic        [9:0]  Y_LO     = 10'(Y_MIN);
    localparam logic        [9:0]  Y_HI     = 10'(Y_MAX);
    localparam logic signed [11:0] Y_LO_S   = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI_S   = 12'(Y_MAX);
    localparam logic signed [11:0] V_MAX    = 12'(MAX_STEP);
    localparam logic signed [11:0] V_MIN    = 12'(-MAX_STEP);
    localparam logic signed [10:0] DZ       = 11'(DEADZONE);
    localparam logic signed [10:0] SAT_HI   = 11'sd511;
    localparam logic signed [10:0] SAT_LO   = -11'sd512;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_CALC  = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    state_t                   state;
    logic signed [9:0]        ring [DEPTH];
    logic        [PTR_W-1:0]  wp;
    logic        [CNT_W-1:0]  fill_cnt;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_nxt;
    logic signed [9:0]        avg_cur;
    logic signed [9:0]        offset;
    logic signed [10:0]       corr;
    logic signed [9:0]        corr_sat;
    logic                     fill_done;

    logic signed [10:0]       tilt_ext;
    logic signed [10:0]       tilt_abs;
    logic signed [9:0]        tilt_shr;
    logic signed [11:0]       shr_ext;
    logic signed [11:0]       vel_calc;
    logic signed [11:0]       vel;
    logic signed [11:0]       pos_sum;
    logic        [9:0]        pos_clamped;

    // ------------------------------------------------------------------
    // Moving-average filter
    // ------------------------------------------------------------------
    always_comb begin
        sum_nxt   = sum - SUM_W'(ring[wp]) + SUM_W'(sample_in);
        avg_cur   = 10'(sum >>> AVG_LOG2);
        fill_done = (state == S_FILL) && sample_valid &&
                    (fill_cnt == CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            sum      <= '0;
            wp       <= '0;
            tilt_avg <= '0;
        end else begin
            if (sample_valid) begin
                ring[wp] <= sample_in;
                sum      <= sum_nxt;
                wp       <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
            end
            tilt_avg <= corr_sat;
        end
    end

`ifdef ACL_CAL_EN
    // Offset is the average including the sample that completes the fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset <= '0;
        end else if (fill_done) begin
            offset <= 10'(sum_nxt >>> AVG_LOG2);
        end
    end
`else
    assign offset = '0;
`endif

    always_comb begin
        corr = 11'(avg_cur) - 11'(offset);
        if (corr > SAT_HI) begin
            corr_sat = 10'sd511;
        end else if (corr < SAT_LO) begin
            corr_sat = -10'sd512;
        end else begin
            corr_sat = corr[9:0];
        end
    end

    // ------------------------------------------------------------------
    // Velocity and position arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        tilt_ext = 11'(tilt_avg);
        tilt_abs = tilt_ext[10] ? -tilt_ext : tilt_ext;
        tilt_shr = tilt_avg >>> VEL_SHIFT;
        shr_ext  = 12'(tilt_shr);
        if (tilt_abs <= DZ) begin
            vel_calc = '0;
        end else if (shr_ext > V_MAX) begin
            vel_calc = V_MAX;
        end else if (shr_ext < V_MIN) begin
            vel_calc = V_MIN;
        end else begin
            vel_calc = shr_ext;
        end
    end

    // Widened to 12 bits so an upward step from row 0 cannot wrap.
    always_comb begin
        pos_sum = $signed({2'b00, paddle_y}) + vel;
        if (pos_sum < Y_LO_S) begin
            pos_clamped = Y_LO;
        end else if (pos_sum > Y_HI_S) begin
            pos_clamped = Y_HI;
        end else begin
            pos_clamped = pos_sum[9:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FILL;
            fill_cnt   <= '0;
            cal_done   <= 1'b0;
            vel        <= '0;
            paddle_y   <= Y_HOME;
            paddle_upd <= 1'b0;
        end else begin
            paddle_upd <= 1'b0;
            case (state)
                S_FILL: begin
                    if (sample_valid) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
                    if (fill_done) begin
                        state    <= S_RUN;
                        cal_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (frame_tick) begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    vel   <= vel_calc;
                    state <= S_APPLY;
                end
                S_APPLY: begin
                    if (!frz) begin
                        paddle_y <= pos_clamped;
                    end
                    paddle_upd <= 1'b1;
                    state      <= S_RUN;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/acl_paddle_ctrl.md
Name: acl_paddle_ctrl

Overview:
- Sits between the per-player SPI accelerometer readers and the VGA/game renderer.
- Consumes raw 10-bit signed y-axis tilt samples (one strobe per SPI transfer, ~5 Hz).
- Filters them with a moving average, applies a dead zone, and converts the result to a saturated per-frame velocity.
- Integrates that velocity into a clamped paddle Y position, updated once per video frame.

Parameters:
- AVG_LOG2, 2, log2 of moving-average depth (depth = 4).
- DEADZONE, 16, |avg| at or below this gives zero velocity.
- VEL_SHIFT, 4, velocity = avg arithmetically shifted right by this.
- MAX_STEP, 8, velocity saturation magnitude (pixels per frame).
- Y_MIN, 0, top clamp of paddle_y.
- Y_MAX, 400, bottom clamp of paddle_y (480 − paddle height 80).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous, active-low reset.
- sample_in, in, 10, signed two's-complement y-axis tilt.
- sample_valid, in, 1, one-cycle strobe; sample_in is valid this cycle.
- frame_tick, in, 1, one-cycle strobe per video frame (start of vblank).
- frz, in, 1, freeze; while high paddle_y holds.
- tilt_avg, out, 10, signed filtered tilt (calibration-corrected when enabled).
- paddle_y, out, 10, unsigned paddle top-edge row.
- paddle_upd, out, 1, one-cycle pulse when paddle_y has been written.
- cal_done, out, 1, high once tilt_avg is meaningful.

Behaviour:
- Reset (rst=0, async): paddle_y = (Y_MIN+Y_MAX)/2 = 200, tilt_avg = 0, paddle_upd = 0, cal_done = 0. Ring buffer, sum, fill counter, write pointer and offset clear. FSM → FILL.
- Ring buffer: 2^AVG_LOG2 entries × 10 bits.
  - Running sum is signed, 10+AVG_LOG2 bits. On each sample_valid: sum ← sum − buf[wp] + sample_in; buf[wp] ← sample_in; wp increments and wraps modulo depth.
  - Emptied entries read as 0.
- avg = sum >>> AVG_LOG2 (arithmetic shift, floor). tilt_avg is registered and updates the cycle after the sum changes.
- FSM states:
  - FILL: counts accepted samples. On the depth-th sample → RUN, and cal_done asserts the next cycle. frame_tick in FILL updates nothing and gives no paddle_upd.
  - RUN: on frame_tick → CALC.
  - CALC (1 cycle): if |tilt_avg| ≤ DEADZONE, vel = 0. Otherwise vel = tilt_avg >>> VEL_SHIFT, saturated to ±MAX_STEP. Then → APPLY.
  - APPLY (1 cycle): if frz = 0, paddle_y ← clamp(paddle_y + vel, Y_MIN, Y_MAX), computed in 12-bit signed so there is no wrap. If frz = 1, paddle_y holds. paddle_upd = 1 in both cases. Then → RUN.
- Latency: frame_tick at cycle N → paddle_y valid and paddle_upd high at cycle N+2.
- Positive tilt increases paddle_y (moves down the screen).
- frame_tick arriving in CALC or APPLY is dropped, with no queueing.
- sample_valid is accepted in every state, including CALC/APPLY. CALC uses the tilt_avg registered at entry to CALC.
- sample_valid and frame_tick in the same cycle: the sample is accepted; the frame update uses the pre-sample average.
- frz has no effect on filtering. Samples keep accumulating while frozen.
- Reset mid-pipeline aborts the update; no paddle_upd is emitted.

Optional Feature:
- Macro: ACL_CAL_EN.
- Defined:
  - On FILL → RUN, the first complete average is latched as a 10-bit signed offset.
  - Thereafter tilt_avg = avg − offset, saturated to [−512, 511].
  - cal_done rises with the latch. Recalibration happens only via reset.
- Undefined: offset is constantly 0, and cal_done rises on FILL → RUN as above.

Test Plan:
- Reset release, 4× sample_valid with sample_in = 100, then frame_tick → tilt_avg = 100, cal_done = 1, paddle_y 200 → 206 two cycles after the tick, paddle_upd one pulse.
  - With ACL_CAL_EN: tilt_avg = 0 and paddle_y stays 200.
- Dead zone: steady samples 16 → paddle_y unchanged over 10 frames. Steady samples 17 → +1 per frame.
- Saturation and clamp: steady −300 → vel −8 per frame; after 26 frames paddle_y = 0 and stays 0. Steady +400 → +8 per frame; stops at 400.
- frz = 1 with steady 100 for 5 frames → paddle_y constant, paddle_upd still pulses. Release frz → next frame +6.
- Concurrency:
  - sample_valid together with frame_tick → sample counted; update uses the old average.
  - Second frame_tick one cycle after the first → exactly one update.
- Async reset asserted during CALC → paddle_y = 200 immediately, no paddle_upd, FSM in FILL. Three samples then frame_tick → no update.
